// File: rtl/rv32_div_seq.sv
// rv32_div_seq: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU
module rv32_div_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_in,
    input  logic [1:0]  op_in,
    input  logic [31:0] dividend_in,
    input  logic [31:0] divisor_in,
    input  logic        kill_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [31:0] result_out
);
    localparam int ITER = 32 / BITS_PER_CYCLE;

    generate
        if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) begin : g_bad_bpc
            $error("rv32_div_seq: BITS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic        rsel_q, rsel_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] res_q, res_d;

    logic        sgn, a_neg, b_neg, div_zero, ovf;
    logic [31:0] a_mag, b_mag, r, q, quo_fix, rem_fix;
    logic [32:0] t;

    // Next-state logic: operand capture, iteration chain, sign fixup, kill override
    always_comb begin
        state_d   = state_q;
        rsel_d    = rsel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        sgn       = !op_in[0];
        a_neg     = sgn & dividend_in[31];
        b_neg     = sgn & divisor_in[31];
        a_mag     = a_neg ? -dividend_in : dividend_in;
        b_mag     = b_neg ? -divisor_in : divisor_in;
        div_zero  = divisor_in == 32'd0;
        ovf       = sgn && dividend_in == 32'h8000_0000 && divisor_in == 32'hFFFF_FFFF;
        r         = rem_q;
        q         = quo_q;
        t         = 33'd0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            t = {r, q[31]};
            q = {q[30:0], 1'b0};
            if (t >= {1'b0, dvs_q}) begin
                t    = t - {1'b0, dvs_q};
                q[0] = 1'b1;
            end
            r = t[31:0];
        end
        quo_fix = neg_quo_q ? -quo_q : quo_q;
        rem_fix = neg_rem_q ? -rem_q : rem_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    rsel_d    = op_in[1];
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    quo_d     = a_mag;
                    dvs_d     = b_mag;
                    rem_d     = 32'd0;
                    cnt_d     = 5'(ITER - 1);
                    if (div_zero) begin
                        res_d   = op_in[1] ? dividend_in : 32'hFFFF_FFFF;
                        state_d = DONE;
                    end else if (ovf) begin
                        res_d   = op_in[1] ? 32'd0 : 32'h8000_0000;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d   = r;
                quo_d   = q;
                cnt_d   = cnt_q - 5'd1;
                state_d = (cnt_q == 5'd0) ? FIX : RUN;
            end
            FIX: begin
                res_d   = rsel_q ? rem_fix : quo_fix;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (kill_in) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rsel_q    <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            rem_q     <= 32'd0;
            cnt_q     <= 5'd0;
            res_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            rsel_q    <= rsel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
        end
    end

    assign busy_out   = (state_q == RUN) || (state_q == FIX);
    assign done_out   = state_q == DONE;
    assign result_out = res_q;
endmodule

// File: tb/tb_rv32_div_seq.sv
// tb_rv32_div_seq: directed checks of rv32_div_seq at 1, 2 and 4 bits per cycle
module tb_rv32_div_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0, start2 = 1'b0, start4 = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        busy1, busy2, busy4, done1, done2, done4;
    logic [31:0] res1, res2, res4;
    logic        d_busy, d_done;
    logic [31:0] d_res;
    int          cur = 1;
    int          total = 0;
    int          bad = 0;

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    always #5 clk = ~clk;

    rv32_div_seq #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start_in(start1), .op_in(op), .dividend_in(a), .divisor_in(b),
        .kill_in(kill), .busy_out(busy1), .done_out(done1), .result_out(res1));
    rv32_div_seq #(.BITS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .reset(reset), .start_in(start2), .op_in(op), .dividend_in(a), .divisor_in(b),
        .kill_in(kill), .busy_out(busy2), .done_out(done2), .result_out(res2));
    rv32_div_seq #(.BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset(reset), .start_in(start4), .op_in(op), .dividend_in(a), .divisor_in(b),
        .kill_in(kill), .busy_out(busy4), .done_out(done4), .result_out(res4));

    // Route the outputs of whichever instance is under test
    always_comb begin
        d_busy = cur == 2 ? busy2 : cur == 4 ? busy4 : busy1;
        d_done = cur == 2 ? done2 : cur == 4 ? done4 : done1;
        d_res  = cur == 2 ? res2 : cur == 4 ? res4 : res1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 1) start1 = v;
        else if (s == 2) start2 = v;
        else start4 = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; that cycle is cycle 0 (acceptance)
    task automatic run_op(input string tag, input int sel, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat, input bit hold);
        int done_cyc;
        int busy_bad;
        cur = sel;
        op = o;
        a = x;
        b = y;
        set_start(sel, 1'b1);
        done_cyc = -1;
        busy_bad = 0;
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            step();
            if (!hold) set_start(sel, 1'b0);
            if (d_done) begin
                done_cyc = c;
                if (d_busy) busy_bad++;
            end else if (d_busy != (c < exp_lat)) begin
                busy_bad++;
            end
        end
        set_start(sel, 1'b0);
        chk({tag, "_lat"}, done_cyc, exp_lat);
        chk({tag, "_res"}, d_res, exp);
        chk({tag, "_busy"}, busy_bad, 0);
        step();
        chk({tag, "_idle"}, {30'd0, d_busy, d_done}, 32'd0);
    endtask

    initial begin
        int nd;
        repeat (3) step();
        chk("rst_busy", {29'd0, busy1, busy2, busy4}, 32'd0);
        chk("rst_done", {29'd0, done1, done2, done4}, 32'd0);
        chk("rst_res", res1 | res2 | res4, 32'd0);
        reset = 1'b0;
        step();

        run_op("div100_7",  1, DIV,  32'd100,        32'd7,          32'd14,         34, 1'b0);
        run_op("rem100_7",  1, REM,  32'd100,        32'd7,          32'd2,          34, 1'b0);
        run_op("div_m7_2",  1, DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 1'b0);
        run_op("rem_m7_2",  1, REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 1'b0);
        run_op("rem_7_m2",  1, REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34, 1'b0);
        run_op("divu_max1", 1, DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, 1'b0);
        run_op("remu_max16",1, REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          34, 1'b0);
        run_op("div_by0",   1, DIV,  32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1,  1'b0);
        run_op("remu_by0",  1, REMU, 32'h1234_5678,  32'd0,          32'h1234_5678,  1,  1'b0);

        // Kill at cycle 10 of a DIV; result must keep 0x12345678
        cur = 1;
        op = DIV;
        a = 32'd1000;
        b = 32'd3;
        start1 = 1'b1;
        nd = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            start1 = 1'b0;
            if (done1) nd++;
        end
        chk("kill_busy_c10", {31'd0, busy1}, 32'd1);
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_idle", {30'd0, busy1, done1}, 32'd0);
        chk("kill_nodone", nd, 0);
        chk("kill_res_hold", res1, 32'h1234_5678);
        step();
        run_op("divu_9_3",  1, DIVU, 32'd9,          32'd3,          32'd3,          34, 1'b0);

        run_op("div_ovf",   1, DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  1'b0);
        run_op("rem_ovf",   1, REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  1'b0);

        // kill together with start in IDLE: nothing accepted
        op = DIV;
        a = 32'd50;
        b = 32'd5;
        start1 = 1'b1;
        kill = 1'b1;
        step();
        start1 = 1'b0;
        kill = 1'b0;
        chk("kill_start_idle", {30'd0, busy1, done1}, 32'd0);

        run_op("hold_bpc1", 1, DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 1'b1);
        run_op("hold_bpc2", 2, DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  18, 1'b1);
        run_op("hold_bpc4", 4, DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  10, 1'b1);
        run_op("rem_bpc2",  2, REM,  32'd100,        32'd7,          32'd2,          18, 1'b0);
        run_op("div_bpc4",  4, DIV,  32'd100,        32'd7,          32'd14,         10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
